// File: rtl/bogey_counter_if.sv
// Purpose : bundles the sensor, clear and count signals of one counting point.
// Latency : n/a (wires only).
// Backpressure: none; sensors are free-running levels, counts are plain registers.
//
// Ports (master = stimulus/consumer side, slave = bogey_counter):
//   Sensor_a, Sensor_b : raw wheel sensors, 1 = wheel present
//   Clear              : single-cycle pulse that zeroes counts and Dir_err
//   Count_a2b/b2a      : saturating per-direction bogey counts
//   Dir_err            : sticky fault flag
//   Busy               : decoder is mid-sequence
interface bogey_counter_if #(
  parameter int COUNT_W = 4
);
  logic               Sensor_a;
  logic               Sensor_b;
  logic               Clear;
  logic [COUNT_W-1:0] Count_a2b;
  logic [COUNT_W-1:0] Count_b2a;
  logic               Dir_err;
  logic               Busy;

  modport master (
    output Sensor_a, Sensor_b, Clear,
    input  Count_a2b, Count_b2a, Dir_err, Busy
  );

  modport slave (
    input  Sensor_a, Sensor_b, Clear,
    output Count_a2b, Count_b2a, Dir_err, Busy
  );
endinterface

// File: rtl/bogey_counter.sv
// Purpose : counting point; conditions two wheel sensors, decodes travel direction, keeps saturating counts.
// Latency : raw release of the last sensor -> count change in 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; Clear is honoured every cycle, a fault entry beats a coincident Clear.
//
// Ports:
//   Clk      : system clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : bogey_counter_if.slave (Sensor_a, Sensor_b, Clear in; Count_a2b, Count_b2a, Dir_err, Busy out)
module bogey_counter #(
  parameter int COUNT_W         = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic           Clk,
  input  logic           Reset_n,
  bogey_counter_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0]    TM_LAST = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TM_W-1:0]    TM_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    A_FIRST   = 4'd1,
    A_BOTH    = 4'd2,
    A_LAST    = 4'd3,
    B_FIRST   = 4'd4,
    B_BOTH    = 4'd5,
    B_LAST    = 4'd6,
    FAULT     = 4'd7,
    WAIT_IDLE = 4'd8
  } state_t;

  // Bit 1 carries sensor A, bit 0 sensor B, so the pair reads as {a,b}.
  logic [1:0]      sens_meta;
  logic [1:0]      sens_sync;
  logic [1:0]      sens_filt;
  logic [DB_W-1:0] db_cnt [2];

  state_t          state_q;
  state_t          state_n;
  logic [TM_W-1:0] tmr_q;
  logic            timed_state;
  logic            inc_a2b;
  logic            inc_b2a;

  logic [COUNT_W-1:0] cnt_a2b_q;
  logic [COUNT_W-1:0] cnt_b2a_q;
  logic               dir_err_q;

  // ---------------------------------------------------------------------
  // Two-flop synchroniser for both raw sensors.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sens_meta <= '0;
      sens_sync <= '0;
    end else begin
      sens_meta <= {bus.Sensor_a, bus.Sensor_b};
      sens_sync <= sens_meta;
    end
  end

  // ---------------------------------------------------------------------
  // Debounce: the filtered value follows the synchronised value only after
  // DEBOUNCE_CYCLES consecutive cycles of disagreement. A single agreeing
  // cycle restarts the count, so bounces shorter than the window vanish.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sens_filt <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sens_sync[i] == sens_filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sens_filt[i] <= sens_sync[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Decode FSM: state register and dwell timer.
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_n;
      if (state_n != state_q) begin
        tmr_q <= '0;
      end else if (tmr_q != TM_MAX) begin
        tmr_q <= tmr_q + TM_W'(1);
      end
    end
  end

  // IDLE and WAIT_IDLE may legitimately last forever; FAULT leaves anyway.
  assign timed_state = (state_q != IDLE) && (state_q != WAIT_IDLE) && (state_q != FAULT);

  always_comb begin
    state_n = state_q;
    inc_a2b = 1'b0;
    inc_b2a = 1'b0;

    case (state_q)
      IDLE: begin
        case (sens_filt)
          2'b10:   state_n = A_FIRST;
          2'b01:   state_n = B_FIRST;
          2'b11:   state_n = FAULT;
          default: state_n = IDLE;
        endcase
      end

      // A side: wheel covers A, then both, then only B.
      A_FIRST: begin
        case (sens_filt)
          2'b11:   state_n = A_BOTH;
          2'b00:   state_n = IDLE;      // wheel backed off, nothing counted
          2'b01:   state_n = FAULT;
          default: state_n = A_FIRST;
        endcase
      end
      A_BOTH: begin
        case (sens_filt)
          2'b01:   state_n = A_LAST;
          2'b10:   state_n = A_FIRST;   // rocking back onto A only
          2'b00:   state_n = FAULT;
          default: state_n = A_BOTH;
        endcase
      end
      A_LAST: begin
        case (sens_filt)
          2'b00: begin
            state_n = IDLE;
            inc_a2b = 1'b1;
          end
          2'b11:   state_n = A_BOTH;
          2'b10:   state_n = FAULT;
          default: state_n = A_LAST;
        endcase
      end

      // B side: mirror image with the sensors swapped.
      B_FIRST: begin
        case (sens_filt)
          2'b11:   state_n = B_BOTH;
          2'b00:   state_n = IDLE;
          2'b10:   state_n = FAULT;
          default: state_n = B_FIRST;
        endcase
      end
      B_BOTH: begin
        case (sens_filt)
          2'b10:   state_n = B_LAST;
          2'b01:   state_n = B_FIRST;
          2'b00:   state_n = FAULT;
          default: state_n = B_BOTH;
        endcase
      end
      B_LAST: begin
        case (sens_filt)
          2'b00: begin
            state_n = IDLE;
            inc_b2a = 1'b1;
          end
          2'b11:   state_n = B_BOTH;
          2'b01:   state_n = FAULT;
          default: state_n = B_LAST;
        endcase
      end

      FAULT: state_n = WAIT_IDLE;

      // Only a fully clear track re-arms the decoder.
      WAIT_IDLE: begin
        if (sens_filt == 2'b00) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase

    // A stuck wheel (or a dead sensor) must not hold the decoder forever.
    if (timed_state && (state_n == state_q) && (tmr_q == TM_LAST)) begin
      state_n = FAULT;
    end
  end

  // ---------------------------------------------------------------------
  // Counts and fault flag. Clear zeroes everything but still lets a
  // coincident increment land (count becomes 1) and a coincident fault
  // entry win (Dir_err stays set).
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_a2b_q <= '0;
      cnt_b2a_q <= '0;
    end else if (bus.Clear) begin
      cnt_a2b_q <= inc_a2b ? CNT_ONE : '0;
      cnt_b2a_q <= inc_b2a ? CNT_ONE : '0;
    end else begin
      if (inc_a2b && (cnt_a2b_q != CNT_MAX)) begin
        cnt_a2b_q <= cnt_a2b_q + CNT_ONE;
      end
      if (inc_b2a && (cnt_b2a_q != CNT_MAX)) begin
        cnt_b2a_q <= cnt_b2a_q + CNT_ONE;
      end
    end
  end

  // FAULT lasts exactly one cycle, so state_n == FAULT marks the entry edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dir_err_q <= 1'b0;
    end else if (state_n == FAULT) begin
      dir_err_q <= 1'b1;
    end else if (bus.Clear) begin
      dir_err_q <= 1'b0;
    end
  end

  assign bus.Count_a2b = cnt_a2b_q;
  assign bus.Count_b2a = cnt_b2a_q;
  assign bus.Dir_err   = dir_err_q;
  assign bus.Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bogey_counter.sv
// Purpose : self-checking bench for bogey_counter (COUNT_W=4, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64).
// Latency : inputs change and outputs are sampled on the falling clock edge.
// Backpressure: n/a; count changes are matched against a queue of expected count pairs.
module tb_bogey_counter;

  localparam int CW = 4;
  localparam int DB = 4;
  localparam int TO = 64;
  localparam int LAT = 2 + DB + 1;

  logic Clk;
  logic Reset_n;

  bogey_counter_if #(.COUNT_W(CW)) bus ();

  bogey_counter #(
    .COUNT_W        (CW),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int a2b;
    int b2a;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic mon_en   = 1'b0;
  logic [2*CW-1:0] mon_prev = '0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int a2b, input int b2a);
    exp_t e;
    e.a2b = a2b;
    e.b2a = b2a;
    exp_q.push_back(e);
  endtask

  // Every change of the count pair must match the next queued expectation.
  always @(negedge Clk) begin
    if (mon_en && ({bus.Count_a2b, bus.Count_b2a} != mon_prev)) begin
      check_eq("sb_change_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("sb_a2b", int'(bus.Count_a2b), mon_e.a2b);
        check_eq("sb_b2a", int'(bus.Count_b2a), mon_e.b2a);
      end
    end
    mon_prev = {bus.Count_a2b, bus.Count_b2a};
  end

  // Called on a falling edge; leaves the pair in place for n cycles.
  task automatic hold_ab(input logic a, input logic b, input int n);
    bus.Sensor_a = a;
    bus.Sensor_b = b;
    repeat (n) @(negedge Clk);
  endtask

  task automatic a2b_seq(input int h);
    hold_ab(1'b1, 1'b0, h);
    hold_ab(1'b1, 1'b1, h);
    hold_ab(1'b0, 1'b1, h);
    hold_ab(1'b0, 1'b0, h);
  endtask

  task automatic b2a_seq(input int h);
    hold_ab(1'b0, 1'b1, h);
    hold_ab(1'b1, 1'b1, h);
    hold_ab(1'b1, 1'b0, h);
    hold_ab(1'b0, 1'b0, h);
  endtask

  task automatic pulse_clear();
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic busy_seen;

    Reset_n      = 1'b0;
    bus.Sensor_a = 1'b0;
    bus.Sensor_b = 1'b0;
    bus.Clear    = 1'b0;

    // Reset held with sensors toggling: outputs pinned to zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      bus.Sensor_a = i[0];
      bus.Sensor_b = i[1];
    end
    @(negedge Clk);
    check_eq("rst_a2b",  int'(bus.Count_a2b), 0);
    check_eq("rst_b2a",  int'(bus.Count_b2a), 0);
    check_eq("rst_err",  int'(bus.Dir_err),   0);
    check_eq("rst_busy", int'(bus.Busy),      0);

    bus.Sensor_a = 1'b0;
    bus.Sensor_b = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (20) @(negedge Clk);
    check_eq("post_rst_a2b",  int'(bus.Count_a2b), 0);
    check_eq("post_rst_b2a",  int'(bus.Count_b2a), 0);
    check_eq("post_rst_err",  int'(bus.Dir_err),   0);
    check_eq("post_rst_busy", int'(bus.Busy),      0);
    mon_prev = {bus.Count_a2b, bus.Count_b2a};
    mon_en   = 1'b1;

    // Four clean A-to-B bogeys with an exact latency check on each.
    for (int n = 1; n <= 4; n++) begin
      push_exp(n, 0);
      hold_ab(1'b1, 1'b0, 10);
      hold_ab(1'b1, 1'b1, 10);
      hold_ab(1'b0, 1'b1, 10);
      hold_ab(1'b0, 1'b0, LAT - 1);
      check_eq("lat_before_a2b", int'(bus.Count_a2b), n - 1);
      @(negedge Clk);
      check_eq("lat_at_a2b", int'(bus.Count_a2b), n);
      repeat (5) @(negedge Clk);
    end
    check_eq("a2b_run_b2a", int'(bus.Count_b2a), 0);

    // Short glitches on A while idle must never wake the decoder.
    busy_seen = 1'b0;
    for (int g = 0; g < 3; g++) begin
      bus.Sensor_a = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge Clk);
        busy_seen |= bus.Busy;
      end
      bus.Sensor_a = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(negedge Clk);
        busy_seen |= bus.Busy;
      end
    end
    check_eq("glitch_busy", int'(busy_seen), 0);

    push_exp(4, 1);
    b2a_seq(10);
    check_eq("b2a_one", int'(bus.Count_b2a), 1);

    // Reversal: enter from A and back off; decoder goes busy, nothing counted.
    hold_ab(1'b1, 1'b0, 10);
    check_eq("rev_busy", int'(bus.Busy), 1);
    hold_ab(1'b0, 1'b0, 10);
    check_eq("rev_idle", int'(bus.Busy), 0);
    check_eq("rev_a2b", int'(bus.Count_a2b), 4);

    // Rocking between A_FIRST and A_BOTH still yields a single A-to-B count.
    push_exp(5, 1);
    hold_ab(1'b1, 1'b0, 10);
    hold_ab(1'b1, 1'b1, 10);
    hold_ab(1'b1, 1'b0, 10);
    hold_ab(1'b1, 1'b1, 10);
    hold_ab(0, 1'b1, 10);
    hold_ab(1'b0, 1'b0, 10);
    check_eq("rock_a2b", int'(bus.Count_a2b), 5);
    check_eq("rock_b2a", int'(bus.Count_b2a), 1);

    // Both sensors at once from idle: fault, parked while track stays covered.
    hold_ab(1'b1, 1'b1, 15);
    check_eq("both_err", int'(bus.Dir_err), 1);
    check_eq("both_wait_busy", int'(bus.Busy), 1);
    hold_ab(1'b0, 1'b0, 12);
    check_eq("both_released_busy", int'(bus.Busy), 0);
    check_eq("both_a2b", int'(bus.Count_a2b), 5);

    push_exp(0, 0);
    pulse_clear();
    check_eq("clr1_err", int'(bus.Dir_err), 0);

    // A held on A alone long enough trips the timeout.
    hold_ab(1'b1, 1'b0, 40);
    check_eq("to_early_err", int'(bus.Dir_err), 0);
    hold_ab(1'b1, 1'b0, 50);
    check_eq("to_late_err", int'(bus.Dir_err), 1);
    hold_ab(1'b0, 1'b0, 12);
    check_eq("to_released_busy", int'(bus.Busy), 0);
    pulse_clear();
    check_eq("clr2_err", int'(bus.Dir_err), 0);
    check_eq("clr2_a2b", int'(bus.Count_a2b), 0);
    check_eq("clr2_b2a", int'(bus.Count_b2a), 0);

    // Saturation: 17 bogeys leave the count at 15, no fault.
    for (int n = 1; n <= 17; n++) begin
      if (n <= 15) push_exp(n, 0);
      a2b_seq(6);
      repeat (4) @(negedge Clk);
    end
    check_eq("sat_a2b", int'(bus.Count_a2b), 15);
    check_eq("sat_err", int'(bus.Dir_err), 0);

    // Clear on the completing edge of a B-to-A bogey.
    push_exp(0, 1);
    hold_ab(1'b0, 1'b1, 10);
    hold_ab(1'b1, 1'b1, 10);
    hold_ab(1'b1, 1'b0, 10);
    hold_ab(1'b0, 1'b0, LAT - 1);
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
    check_eq("clr_inc_b2a", int'(bus.Count_b2a), 1);
    check_eq("clr_inc_a2b", int'(bus.Count_a2b), 0);
    repeat (5) @(negedge Clk);

    // Clear on the fault-entry edge: the fault wins.
    push_exp(0, 0);
    hold_ab(1'b1, 1'b1, LAT - 1);
    bus.Clear = 1'b1;
    @(negedge Clk);
    bus.Clear = 1'b0;
    check_eq("clr_fault_err", int'(bus.Dir_err), 1);
    check_eq("clr_fault_b2a", int'(bus.Count_b2a), 0);
    repeat (5) @(negedge Clk);
    hold_ab(1'b0, 1'b0, 12);
    check_eq("final_busy", int'(bus.Busy), 0);

    check_eq("sb_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
